// File: rtl/lut_prog_pkg.sv
// Shared types and constants for the run-time programmable LUT and its loader.
// Truth-table constants are stored with address 0 in bit 0.
package lut_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } lut_prog_state_t;

    localparam int LUT_K_DEFAULT = 4;

    localparam logic [3:0]  TT_AND2 = 4'h8;
    localparam logic [15:0] TT_AND4 = 16'h8000;
    localparam logic [15:0] TT_EQN  = 16'hDAA5;

endpackage

// File: rtl/lut_prog_if.sv
// Configuration and read-port bundle of the programmable LUT.
// master = controller side, slave = LUT.
interface lut_prog_if
    import lut_pkg::*;
#(
    parameter int K = LUT_K_DEFAULT
);
    logic         cfg_start;
    logic         cfg_abort;
    logic         cfg_valid;
    logic         cfg_bit;
    logic         cfg_ready;
    logic         cfg_busy;
    logic         cfg_done;
    logic [K-1:0] address;
    logic         result;

    modport master (
        output cfg_start, cfg_abort, cfg_valid, cfg_bit, address,
        input  cfg_ready, cfg_busy, cfg_done, result
    );

    modport slave (
        input  cfg_start, cfg_abort, cfg_valid, cfg_bit, address,
        output cfg_ready, cfg_busy, cfg_done, result
    );
endinterface

// File: rtl/lut_prog_shift_loader.sv
// Serial truth-table loader: fills a shadow register bit by bit (address 0 first),
// then raises a single-cycle commit strobe while in COMMIT.
module lut_shift_loader
    import lut_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic             cfg_abort,
    input  logic             cfg_valid,
    input  logic             cfg_bit,
    output logic             cfg_ready,
    output logic             cfg_busy,
    output logic             commit,
    output logic [DEPTH-1:0] shadow
);
    // One extra count bit keeps the counter from wrapping before COMMIT is reached.
    localparam int CW = $clog2(DEPTH) + 1;

    lut_prog_state_t  state_q, state_d;
    logic [CW-1:0]    count_q;
    logic [DEPTH-1:0] shadow_q;
    logic             accept;
    logic             restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            shadow_q <= '0;
        end else begin
            state_q <= state_d;
            if (restart) begin
                count_q  <= '0;
                shadow_q <= '0;
            end else if (accept) begin
                shadow_q[count_q[CW-2:0]] <= cfg_bit;
                count_q                   <= count_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (cfg_start) state_d = LOAD;
            LOAD: begin
                if (cfg_abort)
                    state_d = IDLE;
                else if (!cfg_start && cfg_valid && (count_q == CW'(DEPTH - 1)))
                    state_d = COMMIT;
            end
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Abort outranks start, start outranks a data bit.
    always_comb begin
        cfg_ready = (state_q == LOAD);
        cfg_busy  = (state_q != IDLE);
        commit    = (state_q == COMMIT);
        restart   = cfg_start && !cfg_abort && ((state_q == IDLE) || (state_q == LOAD));
        accept    = (state_q == LOAD) && !cfg_abort && !cfg_start && cfg_valid;
    end

    assign shadow = shadow_q;

endmodule

// File: rtl/lut_prog.sv
// Run-time programmable K-input LUT: serial loader plus the active table and read mux.
// The old table keeps answering reads until the commit edge swaps in the new one.
module lut_prog
    import lut_pkg::*;
#(
    parameter int K = LUT_K_DEFAULT
) (
    input  logic     clk,
    input  logic     rst_n,
    lut_prog_if.slave bus
);
    localparam int DEPTH = 2 ** K;

    logic [DEPTH-1:0] shadow;
    logic [DEPTH-1:0] active_q;
    logic             commit;
    logic             done_q;

    lut_shift_loader #(
        .DEPTH (DEPTH)
    ) u_loader (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (bus.cfg_start),
        .cfg_abort (bus.cfg_abort),
        .cfg_valid (bus.cfg_valid),
        .cfg_bit   (bus.cfg_bit),
        .cfg_ready (bus.cfg_ready),
        .cfg_busy  (bus.cfg_busy),
        .commit    (commit),
        .shadow    (shadow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= commit;
            if (commit) active_q <= shadow;
        end
    end

    assign bus.cfg_done = done_q;
    assign bus.result   = active_q[bus.address];

endmodule

// File: tb/tb_lut_prog.sv
// Bench for lut_prog: table vectors, directed load/abort/restart/reset sequences,
// and random per-cycle stimulus against a queue-based reference model.
module tb_lut_prog;
    import lut_pkg::*;

    localparam int K     = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lut_prog_if #(.K(K)) bus();
    lut_prog #(.K(K)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int nvec = 0;
    int nerr = 0;

    // Reference model: bits received so far in the current load, and the active table.
    bit          m_loading, m_committing, m_done;
    bit          m_q[$];
    logic [15:0] m_active;

    typedef struct {
        bit          st, ab, va, bt;
        logic [3:0]  addr;
        logic [3:0]  exp;   // {ready, busy, done, result}
        string       name;
    } vec_t;
    vec_t tv[$];

    task automatic model_reset();
        m_loading = 0; m_committing = 0; m_done = 0;
        m_q.delete();
        m_active = '0;
    endtask

    task automatic model_step(input bit st, ab, va, bt);
        m_done = m_committing;
        if (m_committing) begin
            for (int i = 0; i < DEPTH; i++) m_active[i] = m_q[i];
            m_committing = 0;
        end else if (m_loading) begin
            if (ab) begin
                m_loading = 0;
                m_q.delete();
            end else if (st) begin
                m_q.delete();
            end else if (va) begin
                m_q.push_back(bt);
                if (m_q.size() == DEPTH) begin
                    m_loading = 0;
                    m_committing = 1;
                end
            end
        end else if (st) begin
            m_loading = 1;
            m_q.delete();
        end
    endtask

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp,
                         input logic [3:0] mask);
        nvec++;
        if ((got & mask) !== (exp & mask)) begin
            nerr++;
            $display("FAIL %s: got rdy/bsy/done/res=%b required %b (mask %b) at %0t",
                     name, got, exp, mask, $time);
        end
    endtask

    // One clock cycle: drive, check against the model (and optionally a fixed value), clock.
    task automatic cycle(input bit st, ab, va, bt, input logic [3:0] addr,
                         input string name, input logic [3:0] exp, input logic [3:0] mask);
        logic [3:0] got;
        logic [3:0] mexp;
        bus.cfg_start = st; bus.cfg_abort = ab; bus.cfg_valid = va; bus.cfg_bit = bt;
        bus.address = addr;
        #3;
        got  = {bus.cfg_ready, bus.cfg_busy, bus.cfg_done, bus.result};
        mexp = {m_loading, m_loading | m_committing, m_done, m_active[addr]};
        check({name, "/model"}, got, mexp, 4'hF);
        if (mask != 4'h0) check(name, got, exp, mask);
        @(posedge clk);
        model_step(st, ab, va, bt);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(0, 0, 0, 0, 4'($urandom_range(15)), "idle", 4'h0, 4'h0);
    endtask

    task automatic load_bits(input logic [15:0] tt, input int nbits, input int gap_pct);
        for (int i = 0; i < nbits; i++) begin
            while (int'($urandom_range(99)) < gap_pct)
                cycle(0, 0, 0, 1'($urandom), 4'($urandom_range(15)), "gap",
                      4'b1100, 4'b1110);
            cycle(0, 0, 1, tt[i], 4'($urandom_range(15)), "load_bit", 4'b1100, 4'b1110);
        end
    endtask

    task automatic sweep(input logic [15:0] tt, input string name);
        for (int a = 0; a < DEPTH; a++)
            cycle(0, 0, 0, 0, 4'(a), name, {3'b000, tt[a]}, 4'hF);
    endtask

    initial begin
        logic [15:0] eqn;
        bus.cfg_start = 0; bus.cfg_abort = 0; bus.cfg_valid = 0; bus.cfg_bit = 0;
        bus.address = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Test 1 and IDLE boundary cases as fixed vectors.
        for (int a = 0; a < DEPTH; a++)
            tv.push_back('{0, 0, 0, 0, 4'(a), 4'b0000, "reset_sweep"});
        tv.push_back('{0, 0, 1, 1, 4'h0, 4'b0000, "idle_valid_ignored"});
        tv.push_back('{0, 1, 0, 0, 4'h0, 4'b0000, "idle_abort_ignored"});
        tv.push_back('{1, 0, 1, 1, 4'h3, 4'b0000, "idle_start_valid"});
        tv.push_back('{0, 1, 0, 0, 4'h3, 4'b1100, "load_ready_then_abort"});
        tv.push_back('{0, 0, 0, 0, 4'hF, 4'b0000, "back_to_idle"});
        foreach (tv[i])
            cycle(tv[i].st, tv[i].ab, tv[i].va, tv[i].bt, tv[i].addr, tv[i].name,
                  tv[i].exp, 4'hF);

        // Test 2: AND4 back-to-back; the start cycle also carries a valid 1 that must not count.
        cycle(1, 0, 1, 1, 4'h0, "start_with_valid", 4'b0000, 4'b1110);
        load_bits(TT_AND4, DEPTH, 0);
        cycle(0, 0, 0, 0, 4'hF, "commit_cycle", 4'b0100, 4'b1111);
        cycle(0, 0, 0, 0, 4'hF, "done_pulse", 4'b0011, 4'b1111);
        cycle(0, 0, 0, 0, 4'hF, "done_clear", 4'b0001, 4'b1111);
        sweep(TT_AND4, "and4_sweep");

        // Test 3: equation table with random gaps; expectation built from the formula.
        for (int i = 0; i < DEPTH; i++) begin
            logic a, b, c, d;
            {d, c, b, a} = 4'(i);
            eqn[i] = ~(((a & b & c & d) | (c ^ a)) ^ d);
        end
        cycle(1, 0, 0, 0, 4'h0, "start_eqn", 4'b0000, 4'b1110);
        load_bits(TT_EQN, DEPTH, 40);
        idle(2);
        sweep(eqn, "eqn_sweep");

        // Test 4: AND4 committed, then a partial all-ones load aborted.
        cycle(1, 0, 0, 0, 4'h0, "start_and4", 4'b0000, 4'b1110);
        load_bits(TT_AND4, DEPTH, 0);
        idle(2);
        cycle(1, 0, 0, 0, 4'h0, "start_ones", 4'b0000, 4'b1110);
        load_bits(16'hFFFF, 8, 0);
        cycle(0, 1, 1, 1, 4'hF, "abort_in_load", 4'b1101, 4'b1111);
        for (int i = 0; i < 3; i++)
            cycle(0, 0, 0, 0, 4'hF, "abort_no_done", 4'b0001, 4'b1111);
        sweep(TT_AND4, "after_abort_sweep");

        // Test 5: partial EQN, restart (with a dropped valid), full AND4, start/abort in COMMIT.
        cycle(1, 0, 0, 0, 4'h0, "start_partial", 4'b0000, 4'b1110);
        load_bits(TT_EQN, 10, 20);
        cycle(1, 0, 1, 1, 4'h0, "restart_in_load", 4'b1100, 4'b1110);
        load_bits(TT_AND4, DEPTH, 20);
        cycle(1, 1, 1, 1, 4'h0, "commit_ignores_ctl", 4'b0100, 4'b1110);
        cycle(0, 0, 0, 0, 4'h0, "commit_completes", 4'b0010, 4'b1111);
        sweep(TT_AND4, "restart_sweep");

        // Test 6: reset mid-load with EQN active.
        cycle(1, 0, 0, 0, 4'h0, "start_eqn2", 4'b0000, 4'b1110);
        load_bits(TT_EQN, DEPTH, 0);
        idle(2);
        sweep(TT_EQN, "eqn2_sweep");
        cycle(1, 0, 0, 0, 4'h0, "start_before_reset", 4'b0000, 4'b1110);
        load_bits(TT_AND4, 7, 0);
        bus.cfg_start = 0; bus.cfg_abort = 0; bus.cfg_valid = 0; bus.address = 4'h0;
        rst_n = 1'b0;
        #2;
        check("reset_async", {bus.cfg_ready, bus.cfg_busy, bus.cfg_done, bus.result},
              4'b0000, 4'hF);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        sweep(16'h0000, "post_reset_sweep");

        // Random per-cycle stimulus against the model.
        for (int i = 0; i < 3000; i++)
            cycle(int'($urandom_range(999)) < 10, int'($urandom_range(999)) < 4,
                  int'($urandom_range(99)) < 60, 1'($urandom), 4'($urandom_range(15)),
                  "random", 4'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
